// File: rtl/du_report_sequencer_pkg.sv
//==============================================================================
// Module      : du_report_sequencer_pkg
// Description : Shared definitions for the debug-unit report sequencer:
//               FSM state encoding, default byte width and the fixed
//               report-layout word indices.
//               Optional feature macro: DU_TX_CHECKSUM_EN (adds S_CHKSUM use).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package du_report_sequencer_pkg;

   // FSM state encoding
   localparam int NB_STATE = 4;

   localparam logic [NB_STATE-1:0] S_IDLE    = 4'd0;
   localparam logic [NB_STATE-1:0] S_FETCH   = 4'd1;
   localparam logic [NB_STATE-1:0] S_LATCH   = 4'd2;
   localparam logic [NB_STATE-1:0] S_SEND    = 4'd3;
   localparam logic [NB_STATE-1:0] S_WAIT_TX = 4'd4;
   localparam logic [NB_STATE-1:0] S_CHKSUM  = 4'd5;
   localparam logic [NB_STATE-1:0] S_DONE    = 4'd6;

   typedef enum logic [NB_STATE-1:0] {
      ST_IDLE    = S_IDLE,
      ST_FETCH   = S_FETCH,
      ST_LATCH   = S_LATCH,
      ST_SEND    = S_SEND,
      ST_WAIT_TX = S_WAIT_TX,
      ST_CHKSUM  = S_CHKSUM,
      ST_DONE    = S_DONE
   } state_t;

   // UART byte width
   localparam int C_NB_BYTE = 8;

   // Report layout: PC, cycle counter, then the register file
   localparam int IDX_PC       = 0;
   localparam int IDX_CYCLES   = 1;
   localparam int IDX_REG_BASE = 2;

endpackage

`default_nettype wire

// File: rtl/du_word_serializer.sv
//==============================================================================
// Module      : du_word_serializer
// Description : Holds one report word and hands it out MSB byte first.
//               i_load captures a word and restarts the byte index, i_shift
//               moves to the next byte, o_last_byte flags the final byte.
//               With DU_TX_CHECKSUM_EN defined, an XOR accumulator of every
//               shifted-out byte is kept; i_chk_load loads it as a one-byte
//               word, i_chk_clear zeroes it.
// Ports       : i_clock, i_reset (async, active high)
//               i_load/i_word, i_shift, [i_chk_clear, i_chk_load]
//               o_byte (current MSB byte), o_last_byte
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module du_word_serializer
   import du_report_sequencer_pkg::*;
#(
   parameter int NB_DATA = 32,
   parameter int NB_BYTE = C_NB_BYTE
)
(
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_load,
   input  logic [NB_DATA-1:0] i_word,
   input  logic               i_shift,
`ifdef DU_TX_CHECKSUM_EN
   input  logic               i_chk_clear,
   input  logic               i_chk_load,
`endif
   output logic [NB_BYTE-1:0] o_byte,
   output logic               o_last_byte
);

   localparam int NB_BYTES = NB_DATA / NB_BYTE;
   localparam int NB_BIDX  = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
   localparam logic [NB_BIDX-1:0] LAST_BIDX = NB_BIDX'(NB_BYTES - 1);

   logic [NB_DATA-1:0] r_word_q;
   logic [NB_BIDX-1:0] r_byte_idx;

   assign o_byte      = r_word_q[NB_DATA-1 -: NB_BYTE];
   assign o_last_byte = (r_byte_idx == LAST_BIDX);

`ifdef DU_TX_CHECKSUM_EN
   logic [NB_BYTE-1:0] r_chk;

   // Every byte that leaves the shifter has been acknowledged by the UART
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset)
         r_chk <= '0;
      else if (i_chk_clear)
         r_chk <= '0;
      else if (i_shift)
         r_chk <= r_chk ^ o_byte;
   end
`endif

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_word_q   <= '0;
         r_byte_idx <= '0;
      end else if (i_load) begin
         r_word_q   <= i_word;
         r_byte_idx <= '0;
`ifdef DU_TX_CHECKSUM_EN
      end else if (i_chk_load) begin
         // Checksum goes out as a single byte: park it on top and mark last
         r_word_q   <= NB_DATA'(r_chk) << (NB_DATA - NB_BYTE);
         r_byte_idx <= LAST_BIDX;
`endif
      end else if (i_shift) begin
         r_word_q <= r_word_q << NB_BYTE;
         if (!o_last_byte)
            r_byte_idx <= r_byte_idx + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/du_report_sequencer.sv
//==============================================================================
// Module      : du_report_sequencer
// Description : Walks the halt report (PC, cycles, register file, data-memory
//               window), fetches each word and streams it MSB byte first
//               over the UART TX byte handshake. o_done pulses once after
//               the last byte is acknowledged.
//               Optional feature macro: DU_TX_CHECKSUM_EN appends one XOR
//               checksum byte after the last data byte.
// Ports       : i_clock, i_reset (async, active high), i_start
//               i_pc, i_cycles, i_registers, i_data_memory (read data)
//               i_tx_done / o_tx_data, o_tx_start (UART byte handshake)
//               o_reg_addr, o_mem_addr (registered read addresses)
//               o_busy, o_done
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module du_report_sequencer
   import du_report_sequencer_pkg::*;
#(
   parameter int NB_DATA     = 32,
   parameter int NB_BYTE     = C_NB_BYTE,
   parameter int N_REGS      = 32,
   parameter int NB_REGISTER = 5,
   parameter int N_MEM_WORDS = 16,
   parameter int NB_MEM_ADDR = 4
)
(
   input  logic                   i_clock,
   input  logic                   i_reset,
   input  logic                   i_start,
   input  logic [NB_DATA-1:0]     i_pc,
   input  logic [NB_DATA-1:0]     i_cycles,
   input  logic [NB_DATA-1:0]     i_registers,
   input  logic [NB_DATA-1:0]     i_data_memory,
   input  logic                   i_tx_done,
   output logic [NB_REGISTER-1:0] o_reg_addr,
   output logic [NB_MEM_ADDR-1:0] o_mem_addr,
   output logic [NB_BYTE-1:0]     o_tx_data,
   output logic                   o_tx_start,
   output logic                   o_busy,
   output logic                   o_done
);

   localparam int N_WORDS = 2 + N_REGS + N_MEM_WORDS;
   localparam int NB_WIDX = $clog2(N_WORDS);
   localparam logic [NB_WIDX-1:0] LAST_WIDX = NB_WIDX'(N_WORDS - 1);
   localparam logic [NB_WIDX-1:0] REG_BASE  = NB_WIDX'(IDX_REG_BASE);
   localparam logic [NB_WIDX-1:0] MEM_BASE  = NB_WIDX'(IDX_REG_BASE + N_REGS);

   state_t                 r_state;
   logic [NB_WIDX-1:0]     r_word_idx;
   logic [NB_REGISTER-1:0] r_reg_addr;
   logic [NB_MEM_ADDR-1:0] r_mem_addr;
   logic                   r_tx_start;
   logic                   r_busy;
   logic                   r_done;

   logic [NB_WIDX-1:0]     w_next_idx;
   logic [NB_DATA-1:0]     w_word;
   logic                   w_load;
   logic                   w_shift;
   logic                   w_last_byte;

   assign w_next_idx = r_word_idx + 1'b1;
   assign w_load     = (r_state == ST_LATCH);
   assign w_shift    = (r_state == ST_WAIT_TX) && i_tx_done;

   // Source for the word being latched; read data is valid in LATCH
   always_comb begin
      w_word = i_data_memory;
      if (r_word_idx == NB_WIDX'(IDX_PC))
         w_word = i_pc;
      else if (r_word_idx == NB_WIDX'(IDX_CYCLES))
         w_word = i_cycles;
      else if (r_word_idx < MEM_BASE)
         w_word = i_registers;
   end

`ifdef DU_TX_CHECKSUM_EN
   logic r_chk_phase;
   logic w_chk_clear;
   logic w_chk_load;

   assign w_chk_clear = (r_state == ST_IDLE) && i_start;
   assign w_chk_load  = (r_state == ST_CHKSUM);
`endif

   du_word_serializer #(
      .NB_DATA (NB_DATA),
      .NB_BYTE (NB_BYTE)
   ) u_serializer (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_load      (w_load),
      .i_word      (w_word),
      .i_shift     (w_shift),
`ifdef DU_TX_CHECKSUM_EN
      .i_chk_clear (w_chk_clear),
      .i_chk_load  (w_chk_load),
`endif
      .o_byte      (o_tx_data),
      .o_last_byte (w_last_byte)
   );

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state    <= ST_IDLE;
         r_word_idx <= '0;
         r_reg_addr <= '0;
         r_mem_addr <= '0;
         r_tx_start <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
`ifdef DU_TX_CHECKSUM_EN
         r_chk_phase <= 1'b0;
`endif
      end else begin
         // Pulse outputs are asserted only on the transition into their state
         r_tx_start <= 1'b0;
         r_done     <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_word_idx <= '0;
                  r_busy     <= 1'b1;
                  r_state    <= ST_FETCH;
`ifdef DU_TX_CHECKSUM_EN
                  r_chk_phase <= 1'b0;
`endif
               end
            end
            ST_FETCH: r_state <= ST_LATCH;
            ST_LATCH: begin
               r_tx_start <= 1'b1;
               r_state    <= ST_SEND;
            end
            ST_SEND: r_state <= ST_WAIT_TX;
            ST_WAIT_TX: begin
               if (i_tx_done) begin
                  if (!w_last_byte) begin
                     r_tx_start <= 1'b1;
                     r_state    <= ST_SEND;
                  end else if (r_word_idx == LAST_WIDX) begin
`ifdef DU_TX_CHECKSUM_EN
                     if (r_chk_phase) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                     end else begin
                        r_chk_phase <= 1'b1;
                        r_state     <= ST_CHKSUM;
                     end
`else
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
`endif
                  end else begin
                     // Address for the next word must be in place for FETCH
                     r_word_idx <= w_next_idx;
                     if ((w_next_idx >= REG_BASE) && (w_next_idx < MEM_BASE))
                        r_reg_addr <= NB_REGISTER'(w_next_idx - REG_BASE);
                     else if (w_next_idx >= MEM_BASE)
                        r_mem_addr <= NB_MEM_ADDR'(w_next_idx - MEM_BASE);
                     r_state <= ST_FETCH;
                  end
               end
            end
`ifdef DU_TX_CHECKSUM_EN
            ST_CHKSUM: begin
               r_tx_start <= 1'b1;
               r_state    <= ST_SEND;
            end
`endif
            ST_DONE: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_reg_addr = r_reg_addr;
   assign o_mem_addr = r_mem_addr;
   assign o_tx_start = r_tx_start;
   assign o_busy     = r_busy;
   assign o_done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_du_report_sequencer.sv
//==============================================================================
// Module      : tb_du_report_sequencer
// Description : Self-checking bench for du_report_sequencer. Expected report
//               bytes are queued when a report is started and popped as the
//               DUT requests each UART byte. Honours DU_TX_CHECKSUM_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_du_report_sequencer;

   localparam int NB_DATA     = 32;
   localparam int NB_BYTE     = 8;
   localparam int N_REGS      = 32;
   localparam int NB_REGISTER = 5;
   localparam int N_MEM_WORDS = 16;
   localparam int NB_MEM_ADDR = 4;
   localparam int LIMIT       = 40;
   localparam logic [31:0] PC_VAL  = 32'hAABBCCDD;
   localparam logic [31:0] CYC_VAL = 32'h44444444;

   logic                   i_clock = 1'b0;
   logic                   i_reset = 1'b1;
   logic                   i_start = 1'b0;
   logic [NB_DATA-1:0]     i_pc = PC_VAL;
   logic [NB_DATA-1:0]     i_cycles = CYC_VAL;
   logic [NB_DATA-1:0]     i_registers = '0;
   logic [NB_DATA-1:0]     i_data_memory = '0;
   logic                   i_tx_done = 1'b0;
   logic [NB_REGISTER-1:0] o_reg_addr;
   logic [NB_MEM_ADDR-1:0] o_mem_addr;
   logic [NB_BYTE-1:0]     o_tx_data;
   logic                   o_tx_start;
   logic                   o_busy;
   logic                   o_done;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] sb[$];

   always #5 i_clock = ~i_clock;

   du_report_sequencer #(
      .NB_DATA(NB_DATA), .NB_BYTE(NB_BYTE), .N_REGS(N_REGS),
      .NB_REGISTER(NB_REGISTER), .N_MEM_WORDS(N_MEM_WORDS),
      .NB_MEM_ADDR(NB_MEM_ADDR)
   ) dut (
      .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start),
      .i_pc(i_pc), .i_cycles(i_cycles), .i_registers(i_registers),
      .i_data_memory(i_data_memory), .i_tx_done(i_tx_done),
      .o_reg_addr(o_reg_addr), .o_mem_addr(o_mem_addr),
      .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
      .o_busy(o_busy), .o_done(o_done)
   );

   // Synchronous-read register file and data memory: word = {4{addr}}
   always @(posedge i_clock) begin
      i_registers   <= {4{3'b000, o_reg_addr}};
      i_data_memory <= {4{4'b0000, o_mem_addr}};
   end

   // Queue the full expected byte stream of one report
   task automatic push_report();
      logic [31:0] w;
      logic [7:0]  chk;
      chk = 8'h00;
      for (int k = 0; k < 2 + N_REGS + N_MEM_WORDS; k++) begin
         if (k == 0)               w = PC_VAL;
         else if (k == 1)          w = CYC_VAL;
         else if (k < 2 + N_REGS)  w = {4{8'(k - 2)}};
         else                      w = {4{8'(k - 2 - N_REGS)}};
         for (int b = 3; b >= 0; b--) begin
            sb.push_back(w[b*8 +: 8]);
            chk = chk ^ w[b*8 +: 8];
         end
      end
`ifdef DU_TX_CHECKSUM_EN
      sb.push_back(chk);
`endif
   endtask

   // Advance negedges until o_tx_start is seen; cyc counts edges since call.
   // Pulsed inputs are dropped on the first negedge.
   task automatic wait_tx_start(output int cyc);
      cyc = 0;
      do begin
         @(negedge i_clock);
         i_start   = 1'b0;
         i_tx_done = 1'b0;
         cyc++;
      end while (!o_tx_start && cyc < LIMIT);
   endtask

   // UART model: acknowledge 10 cycles after o_tx_start
   task automatic tx_ack();
      repeat (9) begin
         @(negedge i_clock);
         i_start = 1'b0;
      end
      i_tx_done = 1'b1;
   endtask

   task automatic test_reset();
      logic seen;
      i_reset = 1'b1;
      repeat (3) @(negedge i_clock);
      n_tests++;
      if ({o_reg_addr, o_mem_addr, o_tx_data, o_tx_start, o_busy, o_done} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h required 0",
                  {o_reg_addr, o_mem_addr, o_tx_data, o_tx_start, o_busy, o_done});
      end
      i_reset = 1'b0;
      seen = 1'b0;
      repeat (100) begin
         @(negedge i_clock);
         if (o_tx_start || o_busy || o_done) seen = 1'b1;
      end
      n_tests++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_quiet: activity=%b required 0", seen);
      end
   endtask

   task automatic test_full_report(input bit disturb);
      int cyc, nbytes;
      logic [7:0] exp;
      bit timeout;
      logic seen;
      sb.delete();
      push_report();
      nbytes  = 0;
      timeout = 1'b0;
      i_start = 1'b1;
      while (sb.size() > 0) begin
         wait_tx_start(cyc);
         n_tests++;
         if (!o_tx_start) begin
            n_fail++;
            $display("FAIL tx_start_timeout: byte %0d not requested after %0d cycles", nbytes, cyc);
            timeout = 1'b1;
            break;
         end
         exp = sb.pop_front();
         if (o_tx_data !== exp) begin
            n_fail++;
            $display("FAIL tx_byte[%0d]: got %h required %h (disturb=%0d)", nbytes, o_tx_data, exp, disturb);
         end
         if (disturb && nbytes == 57) i_start = 1'b1;   // ignored while busy
         tx_ack();
         n_tests++;
         if (o_tx_data !== exp) begin
            n_fail++;
            $display("FAIL tx_hold[%0d]: got %h required %h", nbytes, o_tx_data, exp);
         end
         // Keep i_tx_done high one extra cycle: lands in FETCH, must be ignored
         if (disturb && nbytes == 11) @(negedge i_clock);
         nbytes++;
      end
      if (!timeout) begin
         @(negedge i_clock);
         i_tx_done = 1'b0;
         n_tests++;
         if (o_done !== 1'b1 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL done_pulse: done=%b busy=%b required 1 1", o_done, o_busy);
         end
         @(negedge i_clock);
         n_tests++;
         if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_end: done=%b busy=%b required 0 0", o_done, o_busy);
         end
         seen = 1'b0;
         repeat (20) begin
            @(negedge i_clock);
            if (o_tx_start || o_done) seen = 1'b1;
         end
         n_tests++;
         if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL post_report_quiet: activity=%b required 0", seen);
         end
      end
   endtask

   task automatic test_latency();
      int cyc;
      logic [7:0] exp;
      sb.delete();
      push_report();
      i_pc    = 32'h11223344;
      i_start = 1'b1;
      @(negedge i_clock);
      i_start = 1'b0;
      i_pc    = PC_VAL;   // PC must be sampled at LATCH, not at i_start
      wait_tx_start(cyc);
      n_tests++;
      if (cyc + 1 !== 3 || o_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL start_latency: got %0d cycles busy=%b required 3 1", cyc + 1, o_busy);
      end
      for (int b = 0; b < 5; b++) begin
         if (b > 0) wait_tx_start(cyc);
         exp = sb.pop_front();
         n_tests++;
         if (o_tx_data !== exp) begin
            n_fail++;
            $display("FAIL lat_byte[%0d]: got %h required %h", b, o_tx_data, exp);
         end
         if (b == 1 || b == 4) begin
            n_tests++;
            if (cyc !== ((b == 4) ? 3 : 1)) begin
               n_fail++;
               $display("FAIL ack_latency[%0d]: got %0d required %0d", b, cyc, (b == 4) ? 3 : 1);
            end
         end
         tx_ack();
      end
      i_reset = 1'b1;
      @(negedge i_clock);
      i_reset   = 1'b0;
      i_tx_done = 1'b0;
   endtask

   task automatic test_reset_abort();
      int cyc;
      logic [7:0] exp;
      logic seen;
      sb.delete();
      push_report();
      i_start = 1'b1;
      for (int b = 0; b < 120; b++) begin
         wait_tx_start(cyc);
         exp = sb.pop_front();
         n_tests++;
         if (!o_tx_start || o_tx_data !== exp) begin
            n_fail++;
            $display("FAIL abort_byte[%0d]: start=%b got %h required %h", b, o_tx_start, o_tx_data, exp);
         end
         tx_ack();
      end
      @(negedge i_clock);
      i_tx_done = 1'b0;
      i_reset   = 1'b1;
      @(negedge i_clock);
      n_tests++;
      if ({o_reg_addr, o_mem_addr, o_tx_data, o_tx_start, o_busy, o_done} !== '0) begin
         n_fail++;
         $display("FAIL abort_outputs: got %h required 0",
                  {o_reg_addr, o_mem_addr, o_tx_data, o_tx_start, o_busy, o_done});
      end
      i_reset = 1'b0;
      seen = 1'b0;
      repeat (20) begin
         @(negedge i_clock);
         if (o_tx_start || o_busy || o_done) seen = 1'b1;
      end
      n_tests++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_quiet: activity=%b required 0", seen);
      end
      i_start = 1'b1;
      wait_tx_start(cyc);
      n_tests++;
      if (o_tx_start !== 1'b1 || o_tx_data !== 8'hAA || cyc !== 3) begin
         n_fail++;
         $display("FAIL restart_first: start=%b got %h cyc=%0d required 1 aa 3", o_tx_start, o_tx_data, cyc);
      end
      i_reset = 1'b1;
      @(negedge i_clock);
      i_reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_full_report(1'b0);
      test_full_report(1'b1);
      test_latency();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire

// File: doc/du_report_sequencer.md
Name: du_report_sequencer

Overview:
Sequencer between the debug unit control FSM and the UART transmitter. On a start pulse (issued when the processor halts), it walks a fixed report: PC, cycle counter, every register-file entry, then a window of data-memory words. It drives the register and memory read addresses, fetches each word, and serializes it MSB-byte-first into the UART TX byte handshake. It signals completion so the debug unit can raise o_du_done.

Parameters:
NB_DATA, 32, report word width; must be a multiple of NB_BYTE
NB_BYTE, 8, UART byte width
N_REGS, 32, register-file entries dumped
NB_REGISTER, 5, register address width
N_MEM_WORDS, 16, data-memory words dumped, starting at word address 0
NB_MEM_ADDR, 4, memory address width; must be >= clog2(N_MEM_WORDS)

Ports:
i_clock  in  1  system clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_start  in  1  one-cycle pulse that starts a report; ignored while o_busy=1
i_pc  in  NB_DATA  current PC
i_cycles  in  NB_DATA  cycle counter
i_registers  in  NB_DATA  register-file read data, valid 1 cycle after o_reg_addr
i_data_memory  in  NB_DATA  data-memory read data, valid 1 cycle after o_mem_addr
i_tx_done  in  1  UART TX finished the current byte (1-cycle pulse)
o_reg_addr  out  NB_REGISTER  register read address
o_mem_addr  out  NB_MEM_ADDR  data-memory read address
o_tx_data  out  NB_BYTE  byte to transmit; stable from o_tx_start until i_tx_done
o_tx_start  out  1  one-cycle request to transmit o_tx_data
o_busy  out  1  report in progress
o_done  out  1  one-cycle pulse after the last byte's i_tx_done

Behaviour:
- Reset values: all outputs 0, state IDLE, word_idx 0, byte_idx 0. Reset asserted mid-report aborts the report immediately. No o_done is produced and no o_tx_start is produced.
- Word order, word_idx 0..W-1 with W = 2+N_REGS+N_MEM_WORDS:
  - idx 0 is PC.
  - idx 1 is cycles.
  - idx 2..N_REGS+1 are registers, with o_reg_addr = idx-2.
  - The remaining indices are memory words, with o_mem_addr = idx-2-N_REGS.
- o_reg_addr and o_mem_addr are registered. They hold their last value when not addressing their own source.
- States:
  - IDLE: if i_start, clear word_idx and go to FETCH. o_busy becomes 1 on the next edge.
  - FETCH: addresses for word_idx are valid during this cycle. Always go to LATCH.
  - LATCH: capture the source selected by word_idx into word_q, set byte_idx=0, go to SEND.
  - SEND: o_tx_start=1 for exactly this cycle, with o_tx_data = word_q[NB_DATA-1 -: NB_BYTE]. Go to WAIT_TX.
  - WAIT_TX: hold o_tx_data and wait for i_tx_done. When it arrives:
    - shift word_q left by NB_BYTE;
    - if byte_idx < NB_DATA/NB_BYTE-1, increment byte_idx and go to SEND;
    - else if word_idx == W-1, go to DONE;
    - else increment word_idx and go to FETCH.
  - DONE: o_done=1 for one cycle, o_busy=0 on the next edge, go to IDLE.
- i_tx_done outside WAIT_TX is ignored. i_start during any non-IDLE state is ignored. i_start in the DONE cycle is also ignored.
- Minimum latency:
  - i_start to first o_tx_start is 3 cycles (FETCH, LATCH, SEND).
  - Consecutive bytes of one word: i_tx_done to next o_tx_start is 1 cycle.
  - Word boundary: i_tx_done to next o_tx_start is 3 cycles.
- PC and cycles are sampled at their LATCH cycle, not at i_start.

Optional Feature:
DU_TX_CHECKSUM_EN.
- Defined: after the last data byte, a CHKSUM state sends one extra byte before DONE. The byte is the XOR of every transmitted data byte and uses the same SEND/WAIT_TX handshake. The accumulator clears on i_start.
- Undefined: the CHKSUM state and accumulator are absent. WAIT_TX on the last byte goes straight to DONE.

Decomposition:
- Shared package/header (alongside common_defs.v):
  - state encoding localparams (NB_STATE=4);
  - NB_BYTE;
  - report-layout constants: IDX_PC=0, IDX_CYCLES=1, IDX_REG_BASE=2.
- One sub-module, du_word_serializer: holds word_q, byte_idx and (optionally) the checksum accumulator, with load/shift/last_byte handshake. The top keeps the FSM and address generation.

Test Plan:
- Reset then idle: no i_start for 100 cycles -> o_tx_start, o_busy, o_done all stay 0.
- Full report, default parameters, TX model asserting i_tx_done 10 cycles after each o_tx_start:
  - 200 bytes are sent: PC=AABBCCDD sends AA,BB,CC,DD first; cycles=44444444 follows.
  - Each register and memory word is returned by the model as {addr,addr,addr,addr}.
  - o_done pulses once, 1 cycle after the 200th i_tx_done.
- i_start re-pulsed at byte 57 and a stray i_tx_done injected during FETCH -> byte stream identical to the previous test.
- i_reset asserted while waiting for byte 120 -> next edge state IDLE, outputs 0. A following i_start restarts at PC byte AA.
- Latency check: first o_tx_start exactly 3 cycles after i_start. Word boundary i_tx_done to o_tx_start is exactly 3 cycles.
- With DU_TX_CHECKSUM_EN: 201 bytes; the last byte equals the XOR of the previous 200. Without it: exactly 200 bytes.
